// File: rtl/seq_pattern_gen_if.sv
// Serial pattern transmitter bus: request/operands in, serial stream and status pulses out.
// master drives the request side; slave is the transmitter.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic [CNT_W-1:0] gap;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, pattern, len, reps, gap,
        input  x, x_valid, busy, done, err
    );

    modport slave (
        input  start, pattern, len, reps, gap,
        output x, x_valid, busy, done, err
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// MSB-first serial pattern transmitter with repeat count and zero-gap; first bit one cycle after start.
// No backpressure: start is only sampled in IDLE, ignored while busy.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_pattern_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_idx;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             x_q;
    logic             x_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             len_ok;

    assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(WIDTH));

    // Mux by equality so the index may be wider than the pattern needs.
    function automatic logic pick(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) == idx) b = p[i];
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            bit_idx   <= '0;
            gap_q     <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            pat_q     <= bus.pattern;
                            len_q     <= bus.len;
                            gap_q     <= bus.gap;
                            rep_cnt   <= (bus.reps == '0) ? CNT_W'(1) : bus.reps;
                            bit_idx   <= bus.len - LEN_W'(1);
                            x_q       <= pick(bus.pattern, bus.len - LEN_W'(1));
                            x_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= SHIFT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // bit_idx is the bit currently on x; rep_cnt includes the current repetition.
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - LEN_W'(1);
                        x_q     <= pick(pat_q, bit_idx - LEN_W'(1));
                    end else if (rep_cnt != CNT_W'(1)) begin
                        rep_cnt <= rep_cnt - CNT_W'(1);
                        if (gap_q != '0) begin
                            gap_cnt <= gap_q;
                            x_q     <= 1'b0;
                            state   <= GAP;
                        end else begin
                            bit_idx <= len_q - LEN_W'(1);
                            x_q     <= pick(pat_q, len_q - LEN_W'(1));
                        end
                    end else begin
                        rep_cnt   <= '0;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt == CNT_W'(1)) begin
                        gap_cnt <= '0;
                        bit_idx <= len_q - LEN_W'(1);
                        x_q     <= pick(pat_q, len_q - LEN_W'(1));
                        state   <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Table-driven bench for seq_pattern_gen with a bit scoreboard; plus restart-ignore and mid-transfer reset cases.
module tb_seq_pattern_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) bus();
    seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] reps;
        logic [3:0] gap;
        int         t;      // expected stream length in cycles
        bit         err;    // expected illegal-length rejection
    } vec_t;

    vec_t vecs[9];
    logic sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_expected(input vec_t v);
        int r_eff;
        r_eff = (v.reps == 0) ? 1 : int'(v.reps);
        for (int r = 0; r < r_eff; r++) begin
            for (int i = int'(v.len) - 1; i >= 0; i--) sb.push_back(v.pat[i]);
            if (r < r_eff - 1)
                for (int g = 0; g < int'(v.gap); g++) sb.push_back(1'b0);
        end
    endtask

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        bus.pattern = v.pat;
        bus.len     = v.len;
        bus.reps    = v.reps;
        bus.gap     = v.gap;
        bus.start   = 1'b1;
        if (!v.err) push_expected(v);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks every cycle from N+1 to N+T+2; poke re-requests with a different pattern in cycle 2.
    task automatic xfer(input int id, input vec_t v, input bit poke);
        drive_start(v);
        for (int k = 1; k <= v.t + 2; k++) begin
            if (poke && k == 2) begin
                bus.start   = 1'b1;
                bus.pattern = ~v.pat;
            end
            if (poke && k == 3) bus.start = 1'b0;
            chk($sformatf("v%0d.x_valid@%0d", id, k), bus.x_valid, k <= v.t);
            chk($sformatf("v%0d.busy@%0d", id, k), bus.busy, k <= v.t + 1);
            chk($sformatf("v%0d.done@%0d", id, k), bus.done, k == v.t + 1);
            chk($sformatf("v%0d.err@%0d", id, k), bus.err, 0);
            if (bus.x_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL v%0d.x@%0d: got unexpected bit, scoreboard empty", id, k);
                end else begin
                    chk($sformatf("v%0d.x@%0d", id, k), bus.x, sb.pop_front());
                end
            end else begin
                chk($sformatf("v%0d.x_idle@%0d", id, k), bus.x, 0);
            end
            if (k < v.t + 2) @(negedge clk);
        end
        chk($sformatf("v%0d.sb_left", id), sb.size(), 0);
        sb.delete();
    endtask

    task automatic illegal(input int id, input vec_t v);
        drive_start(v);
        chk($sformatf("v%0d.err_pulse", id), bus.err, 1);
        chk($sformatf("v%0d.busy", id), bus.busy, 0);
        chk($sformatf("v%0d.x_valid", id), bus.x_valid, 0);
        chk($sformatf("v%0d.done", id), bus.done, 0);
        @(negedge clk);
        chk($sformatf("v%0d.err_clear", id), bus.err, 0);
        chk($sformatf("v%0d.busy2", id), bus.busy, 0);
    endtask

    initial begin
        vecs[0] = '{pat: 8'h05, len: 4'd3, reps: 4'd1, gap: 4'd0, t: 3,  err: 1'b0};
        vecs[1] = '{pat: 8'h05, len: 4'd3, reps: 4'd3, gap: 4'd2, t: 13, err: 1'b0};
        vecs[2] = '{pat: 8'h05, len: 4'd3, reps: 4'd3, gap: 4'd0, t: 9,  err: 1'b0};
        vecs[3] = '{pat: 8'hA5, len: 4'd8, reps: 4'd0, gap: 4'd0, t: 8,  err: 1'b0};
        vecs[4] = '{pat: 8'h05, len: 4'd0, reps: 4'd1, gap: 4'd0, t: 0,  err: 1'b1};
        vecs[5] = '{pat: 8'h05, len: 4'd9, reps: 4'd1, gap: 4'd0, t: 0,  err: 1'b1};
        vecs[6] = '{pat: 8'h01, len: 4'd1, reps: 4'd4, gap: 4'd0, t: 4,  err: 1'b0};
        vecs[7] = '{pat: 8'h16, len: 4'd5, reps: 4'd2, gap: 4'd1, t: 11, err: 1'b0};
        vecs[8] = '{pat: 8'h06, len: 4'd3, reps: 4'd1, gap: 4'd5, t: 3,  err: 1'b0};

        bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.reps = '0; bus.gap = '0;
        #2;
        chk("rst.x", bus.x, 0);
        chk("rst.x_valid", bus.x_valid, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.err", bus.err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].err) illegal(i, vecs[i]);
            else             xfer(i, vecs[i], 1'b0);
        end

        // Second start during a transfer must be ignored.
        xfer(100, vecs[0], 1'b1);

        // Reset in cycle 2 of a 3-rep transfer abandons it without done.
        drive_start(vecs[1]);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst.x", bus.x, 0);
        chk("mid_rst.x_valid", bus.x_valid, 0);
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.done", bus.done, 0);
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_rst.hold_done@%0d", k), bus.done, 0);
            chk($sformatf("mid_rst.hold_busy@%0d", k), bus.busy, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst.done", bus.done, 0);
        chk("post_rst.busy", bus.busy, 0);
        xfer(200, vecs[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter that drives the single-bit input of the Moore sequence detectors in this codebase. It sends a captured pattern MSB-first, one bit per clock. The pattern can be repeated a programmed number of times with a programmable run of zero bits between repetitions. It is the stimulus/transmit end of the `x` serial stream that the detectors consume, and it reports completion with a one-cycle pulse.

## Interface
Parameters:
- `WIDTH`, 8, maximum pattern length in bits
- `LEN_W`, 4, width of `len`; must satisfy 2^LEN_W > WIDTH
- `CNT_W`, 4, width of `reps` and `gap`

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `pattern`  in  WIDTH  bits to send; bits [len-1:0] are used, bit len-1 is sent first
- `len`  in  LEN_W  pattern length; legal range 1..WIDTH
- `reps`  in  CNT_W  repetition count; 0 is treated as 1
- `gap`  in  CNT_W  zero bits inserted between repetitions; none after the last repetition
- `x`  out  1  serial data bit
- `x_valid`  out  1  high on every cycle that `x` carries a pattern or gap bit
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse after the final bit
- `err`  out  1  one-cycle pulse when a start carries an illegal `len`

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - With `start`=1 and 1≤`len`≤WIDTH: capture `pattern`, `len`, `reps` (0→1) and `gap` into registers, then go to SHIFT.
  - With `start`=1 and `len`=0 or `len`>WIDTH: pulse `err` next cycle and stay in IDLE.
- SHIFT:
  - Output bit index `len-1` down to 0 of the captured pattern, one per cycle, with `x_valid`=1.
  - After bit 0: if repetitions remain and `gap`>0, go to GAP.
  - If repetitions remain and `gap`=0, restart SHIFT at bit `len-1` with no idle cycle.
  - Otherwise go to DONE.
- GAP: `x`=0 and `x_valid`=1 for exactly `gap` cycles, then return to SHIFT at bit `len-1`.
- DONE: lasts one cycle with `done`=1, then goes to IDLE.
- Captured operands are frozen while busy. Input changes during a transfer have no effect.
- `start` while `busy`=1 is ignored. There is no queueing and no `err`.
- Outside SHIFT and GAP, `x`=0 and `x_valid`=0.
- All outputs are registered.
- Counters:
  - Bit index is LEN_W wide.
  - Repetition and gap counters are CNT_W wide and count down.
  - No counter wraps. All terminal tests are equality-to-zero/one checks on the down-counters.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): state=IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0, `err`=0, all counters 0.
- Reset asserted mid-transfer: outputs go to their reset values immediately and the transfer is abandoned. `done` does not pulse.
- `start` accepted at edge N:
  - First bit is on `x` with `x_valid`=1 and `busy`=1 during cycle N+1.
  - Stream length T = R·len + (R−1)·gap, where R is the effective repetition count.
  - `x_valid` is high for exactly T consecutive cycles, N+1..N+T.
  - `done`=1 during cycle N+T+1.
  - IDLE is reached at N+T+2. A new `start` can be accepted at edge N+T+2.
- `err` is high during cycle N+1 for an illegal start at edge N. `busy` stays 0.
- `reps`=1 gives no GAP state regardless of `gap`.
- `len`=1 with `gap`=0 gives a continuous stream of the same bit.

## Test plan
- `pattern`=3'b101, `len`=3, `reps`=1, `gap`=0, start at edge 0 -> `x`=1,0,1 in cycles 1–3 with `x_valid`=1, `done` in cycle 4, `busy` low in cycle 5. A connected "101" detector asserts `y` once.
- `pattern`=101, `len`=3, `reps`=3, `gap`=2 -> stream 1,0,1,0,0,1,0,1,0,0,1,0,1 (13 bits, cycles 1–13), `done` in cycle 14. With `gap`=0 instead -> 101101101 (9 bits), `done` in cycle 10.
- WIDTH=8, `pattern`=8'hA5, `len`=8, `reps`=0 -> 1,0,1,0,0,1,0,1 (treated as 1 rep), `done` in cycle 9.
- `len`=0, then `len`=9 with WIDTH=8 -> `err` pulse in the cycle after each start; `busy`, `x_valid` and `done` stay 0.
- `start` pulsed again in cycle 2 of a 3-bit transfer, with `pattern` changed -> ignored. Output still 1,0,1, exactly one `done`.
- `reset` driven low in cycle 2 of a `reps`=3 transfer -> `x`/`x_valid`/`busy`=0 immediately, no `done`. After release, a fresh start behaves as in the first scenario.
